// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Memory-mapped scan controller for a multiplexed 7-segment display bank.
// NUM_DIGITS hex digits share one set of segment lines; each digit owns a
// slot of 16 PWM phase ticks.  Per-digit blink, 16-level brightness and
// leading-zero blanking gate the lit decision, which is registered onto the
// active-low anode/segment outputs.
//
// Bus handshake: write_enable and read_enable are single-cycle strobes
// sampled on the rising clock edge.  A write updates the addressed register
// on that edge.  A read loads read_data on that edge with the register value
// as it was before the edge, so a same-cycle write+read to one address
// returns the old contents.  read_data holds between reads.

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 97,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [2:0]            address,
  input  logic [15:0]           write_data_in,
  output logic [15:0]           read_data,
  output logic [NUM_DIGITS-1:0] enable,
  output logic [7:0]            value
);

  // Counter widths; a width of at least 1 keeps PRESCALE=1 / BLINK_FRAMES=1 legal.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]         PCNT_LOAD = PW'(PRESCALE - 1);
  localparam logic [FW-1:0]         FCNT_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]            IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE   = NUM_DIGITS'(1);

  // Register file
  logic [15:0] r_data_lo;
  logic [15:0] r_data_hi;
  logic [15:0] r_ctrl;
  logic [12:0] r_mode;

  // Scan state
  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_ph;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_fcnt;
  logic          r_blink_ph;

  // Combinational decode
  logic        w_tick;
  logic        w_slot_end;
  logic        w_frame_end;
  logic [31:0] w_data_all;
  logic [3:0]  w_nib;
  logic [7:0]  w_dig_en;
  logic [7:0]  w_dp_on;
  logic [7:0]  w_blink_mask;
  logic [3:0]  w_bright;
  logic        w_lzb;
  logic [8:0]  w_zero_from;
  logic        w_lz_blank;
  logic        w_lit;
  logic [15:0] w_rd_mux;
  logic        w_unused_addr0;

  assign w_unused_addr0 = address[0];

  assign w_data_all   = {r_data_hi, r_data_lo};
  assign w_dig_en     = r_ctrl[15:8];
  assign w_dp_on      = r_ctrl[7:0];
  assign w_blink_mask = r_mode[7:0];
  assign w_bright     = r_mode[11:8];
  assign w_lzb        = r_mode[12];

  assign w_tick      = (r_pcnt == '0);
  assign w_slot_end  = w_tick && (r_ph == 4'hF);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  assign w_nib = w_data_all[{r_idx, 2'b00} +: 4];

  // 7-segment font, bit 6 = CA ... bit 0 = CG, active-low.
  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

  // w_zero_from[i] = every driven nibble at position i and above is zero.
  always_comb begin
    w_zero_from = '1;
    for (int i = 7; i >= 0; i--) begin
      if (i < NUM_DIGITS) begin
        w_zero_from[i] = w_zero_from[i+1] && (w_data_all[i*4 +: 4] == 4'h0);
      end
    end
  end

  assign w_lz_blank = w_lzb && (r_idx != 3'd0) && w_zero_from[r_idx];

  assign w_lit = w_dig_en[r_idx] &&
                 (r_ph <= w_bright) &&
                 !(r_blink_ph && w_blink_mask[r_idx]) &&
                 !w_lz_blank;

  // Read-back mux; MODE bits 15:13 are not stored and read as zero.
  always_comb begin
    w_rd_mux = '0;
    case (address[2:1])
      2'd0:    w_rd_mux = r_data_lo;
      2'd1:    w_rd_mux = r_data_hi;
      2'd2:    w_rd_mux = r_ctrl;
      default: w_rd_mux = {3'b000, r_mode};
    endcase
  end

  // Register writes from the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_lo <= '0;
      r_data_hi <= '0;
      r_ctrl    <= '0;
      r_mode    <= '0;
    end else if (write_enable) begin
      case (address[2:1])
        2'd0:    r_data_lo <= write_data_in;
        2'd1:    r_data_hi <= write_data_in;
        2'd2:    r_ctrl    <= write_data_in;
        default: r_mode    <= write_data_in[12:0];
      endcase
    end
  end

  // Read data register: loads pre-edge register contents, holds otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data <= '0;
    end else if (read_enable) begin
      read_data <= w_rd_mux;
    end
  end

  // Prescaler: counts down and reloads, producing one PWM phase tick per wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pcnt <= PCNT_LOAD;
    end else if (w_tick) begin
      r_pcnt <= PCNT_LOAD;
    end else begin
      r_pcnt <= r_pcnt - 1'b1;
    end
  end

  // Phase and digit index: 16 phases per slot, idx wraps at the last digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ph  <= 4'd0;
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_ph <= r_ph + 4'd1;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

  // Blink timebase: toggles blink phase every BLINK_FRAMES completed frames.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fcnt     <= '0;
      r_blink_ph <= 1'b0;
    end else if (w_frame_end) begin
      if (r_fcnt == FCNT_LAST) begin
        r_fcnt     <= '0;
        r_blink_ph <= ~r_blink_ph;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // Registered display outputs: one anode low with its glyph, or all dark.
  always_ff @(posedge clock) begin
    if (reset) begin
      enable <= '1;
      value  <= 8'hFF;
    end else if (w_lit) begin
      enable <= ~(DIG_ONE << r_idx);
      value  <= {font(w_nib), ~w_dp_on[r_idx]};
    end else begin
      enable <= '1;
      value  <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed testbench for seg7_scan_ctrl (8 digits, PRESCALE=1, BLINK_FRAMES=1).
// One slot is 16 clocks and one frame 128 clocks, so any window of 128
// consecutive clocks sees every digit's slot exactly once.

module tb_seg7_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        write_enable;
  logic        read_enable;
  logic [2:0]  address;
  logic [15:0] write_data_in;
  logic [15:0] read_data;
  logic [7:0]  enable;
  logic [7:0]  value;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  // Per-window scan statistics.
  int         lit_cnt[8];
  logic [7:0] lit_val[8];
  int         multi_low;
  int         val_bad;
  int         unlit_bad;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (8),
    .PRESCALE    (1),
    .BLINK_FRAMES(1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .write_data_in(write_data_in),
    .read_data    (read_data),
    .enable       (enable),
    .value        (value)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clock);
    write_enable  = 1'b1;
    address       = a;
    write_data_in = d;
    @(negedge clock);
    write_enable  = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clock);
    read_enable = 1'b1;
    address     = a;
    @(negedge clock);
    read_enable = 1'b0;
    d = read_data;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] e);
    logic [15:0] d;
    exp_q.push_back(e);
    bus_read(a, d);
    check(tag, d, exp_q.pop_front());
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Sample outputs for n clocks and tally lit cycles and glyphs per digit.
  task automatic scan(input int n);
    logic [7:0] oh;
    for (int d = 0; d < 8; d++) begin
      lit_cnt[d] = 0;
      lit_val[d] = 8'hFF;
    end
    multi_low = 0;
    val_bad   = 0;
    unlit_bad = 0;
    repeat (n) begin
      @(negedge clock);
      if (enable != 8'hFF) begin
        if ($countones(~enable) != 1) multi_low++;
        for (int d = 0; d < 8; d++) begin
          oh = 8'h01 << d;
          if (enable == ~oh) begin
            if (lit_cnt[d] > 0 && lit_val[d] != value) val_bad++;
            lit_cnt[d]++;
            lit_val[d] = value;
          end
        end
      end else if (value != 8'hFF) begin
        unlit_bad++;
      end
    end
  endtask

  task automatic check_scan(input string tag, input int exp_cnt[8], input logic [7:0] exp_val[8]);
    for (int d = 0; d < 8; d++) begin
      check($sformatf("%s_cnt%0d", tag, d), lit_cnt[d], exp_cnt[d]);
      if (exp_cnt[d] > 0) check($sformatf("%s_val%0d", tag, d), lit_val[d], exp_val[d]);
    end
    check({tag, "_multi_low"}, multi_low, 0);
    check({tag, "_val_unstable"}, val_bad, 0);
    check({tag, "_dark_value"}, unlit_bad, 0);
  endtask

  initial begin
    int         c16[8]  = '{16, 16, 16, 16, 16, 16, 16, 16};
    int         c4[8]   = '{4, 4, 4, 4, 4, 4, 4, 4};
    int         cbl[8]  = '{16, 32, 32, 32, 32, 32, 32, 32};
    int         clz[8]  = '{16, 16, 0, 0, 0, 0, 0, 0};
    int         clz0[8] = '{16, 0, 0, 0, 0, 0, 0, 0};
    int         clz2[8] = '{16, 16, 16, 0, 0, 0, 0, 0};
    int         cen[8]  = '{0, 16, 0, 16, 0, 0, 0, 0};
    logic [7:0] v1[8]   = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h03, 8'h03, 8'h03, 8'h03};
    logic [7:0] vlz[8]  = '{8'h25, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] vlz0[8] = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] vlz2[8] = '{8'h25, 8'h03, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] vdp[8]  = '{8'h02, 8'h9F, 8'h24, 8'h0D, 8'h03, 8'h03, 8'h03, 8'h03};
    int         waited;

    reset         = 1'b1;
    write_enable  = 1'b0;
    read_enable   = 1'b0;
    address       = 3'd0;
    write_data_in = 16'h0000;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_enable", enable, 8'hFF);
    check("rst_value", value, 8'hFF);
    check("rst_read_data", read_data, 16'h0000);
    reset = 1'b0;

    // 1: full brightness, digits 0..3 = 0,1,2,3
    bus_write(3'b100, 16'hFF00);
    bus_write(3'b000, 16'h3210);
    bus_write(3'b110, 16'h0F00);
    @(negedge clock);
    scan(128);
    check_scan("t1", c16, v1);

    // 2: brightness 3 -> 4 of 16 clocks per slot
    bus_write(3'b110, 16'h0300);
    @(negedge clock);
    scan(128);
    check_scan("t2", c4, v1);

    // 3: blink digit 0 with one frame per half-period
    bus_write(3'b110, 16'h0F01);
    @(negedge clock);
    scan(256);
    check_scan("t3", cbl, v1);

    // 4: leading-zero blanking
    bus_write(3'b010, 16'h0000);
    bus_write(3'b000, 16'h0042);
    bus_write(3'b110, 16'h1F00);
    @(negedge clock);
    scan(128);
    check_scan("t4a", clz, vlz);
    bus_write(3'b000, 16'h0000);
    @(negedge clock);
    scan(128);
    check_scan("t4b", clz0, vlz0);
    bus_write(3'b000, 16'h0402);
    @(negedge clock);
    scan(128);
    check_scan("t4c", clz2, vlz2);

    // 5: decimal points, digit enables, read-back
    bus_write(3'b110, 16'h0F00);
    bus_write(3'b000, 16'h3210);
    bus_write(3'b100, 16'hFF05);
    @(negedge clock);
    scan(128);
    check_scan("t5dp", c16, vdp);
    read_check("rd_ctrl", 3'b100, 16'hFF05);
    read_check("rd_ctrl_bit0", 3'b101, 16'hFF05);
    read_check("rd_lo", 3'b000, 16'h3210);
    read_check("rd_hi", 3'b010, 16'h0000);

    @(negedge clock);
    write_enable  = 1'b1;
    read_enable   = 1'b1;
    address       = 3'b110;
    write_data_in = 16'hFFFF;
    @(negedge clock);
    write_enable  = 1'b0;
    read_enable   = 1'b0;
    check("rd_wr_same_old", read_data, 16'h0F00);
    @(negedge clock);
    check("rd_hold", read_data, 16'h0F00);
    read_check("rd_mode_masked", 3'b110, 16'h1FFF);

    bus_write(3'b110, 16'h0F00);
    bus_write(3'b100, 16'h0A00);
    @(negedge clock);
    scan(128);
    check_scan("t5en", cen, v1);

    // 6: reset mid-slot
    bus_write(3'b100, 16'hFF00);
    repeat (21) @(negedge clock);
    pulse_reset();
    check("mid_rst_enable", enable, 8'hFF);
    check("mid_rst_value", value, 8'hFF);
    check("mid_rst_read_data", read_data, 16'h0000);
    read_check("mid_rst_lo", 3'b000, 16'h0000);
    read_check("mid_rst_hi", 3'b010, 16'h0000);
    read_check("mid_rst_ctrl", 3'b100, 16'h0000);
    read_check("mid_rst_mode", 3'b110, 16'h0000);

    // Scan restarts at digit 0: enable display right after a fresh reset.
    repeat (7) @(negedge clock);
    pulse_reset();
    bus_write(3'b100, 16'hFF00);
    bus_write(3'b110, 16'h0F00);
    waited = 0;
    while (enable == 8'hFF && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check("restart_timeout", (waited < 40) ? 1 : 0, 1);
    check("restart_enable", enable, 8'hFE);
    check("restart_value", value, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
